// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight register writes from EX onward, produces
// registered per-operand bypass selects for the instruction entering EX, and
// stalls ID while a load result is not yet forwardable.
module fwd_hazard_unit #(
  parameter  int unsigned AW       = 5,
  parameter  int unsigned NSRC     = 2,
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned LD_READY = 2,
  localparam int unsigned SW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_use,
  input  logic [AW-1:0]        id_rw,
  input  logic                 id_regwr,
  input  logic                 id_isload,
  input  logic                 flush,
  output logic                 id_stall,
  output logic                 ex_valid,
  output logic [NSRC*SW-1:0]   ex_fwd_sel,
  output logic [15:0]          stall_cnt
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rw;
    logic          wr;
    logic          ld;
  } rec_t;

  // The WB record is never searched (the register file covers it), so only
  // stages EX..DEPTH-2 are stored; observable behaviour is unchanged.
  localparam int unsigned NREC = DEPTH - 1;

  rec_t               rec_q [NREC];
  rec_t               rec_d [NREC];
  logic               ex_valid_q, ex_valid_d;
  logic [NSRC*SW-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic [NSRC*SW-1:0] sel_c;
  logic [NSRC-1:0]    haz_c;
  logic               advance;

  // Forward search: oldest-to-youngest scan so the youngest producer wins.
  always_comb begin
    sel_c = '0;
    haz_c = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (id_src_use[i] && (id_src[i*AW +: AW] != '0)) begin
        for (int unsigned k = NREC; k > 0; k--) begin
          if (rec_q[k-1].v && rec_q[k-1].wr && (rec_q[k-1].rw != '0) &&
              (rec_q[k-1].rw == id_src[i*AW +: AW])) begin
            sel_c[i*SW +: SW] = SW'(k);
            haz_c[i]          = rec_q[k-1].ld && (k < LD_READY);
          end
        end
      end
    end
  end

  // Stall/advance decision and next-state for records, EX outputs and counter.
  always_comb begin
    id_stall = id_valid && !flush && (|haz_c);
    advance  = id_valid && !id_stall && !flush;

    rec_d[0] = '0;
    if (advance) begin
      rec_d[0].v  = 1'b1;
      rec_d[0].rw = id_rw;
      rec_d[0].wr = id_regwr;
      rec_d[0].ld = id_isload;
    end
    for (int unsigned j = 1; j < NREC; j++) begin
      rec_d[j] = rec_q[j-1];
    end

    ex_valid_d   = advance;
    ex_fwd_sel_d = advance ? sel_c : '0;

    stall_cnt_d = stall_cnt_q;
    if (id_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NREC; j++) begin
        rec_q[j] <= '0;
      end
      ex_valid_q   <= 1'b0;
      ex_fwd_sel_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      for (int unsigned j = 0; j < NREC; j++) begin
        rec_q[j] <= rec_d[j];
      end
      ex_valid_q   <= ex_valid_d;
      ex_fwd_sel_q <= ex_fwd_sel_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_fwd_sel = ex_fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random
// traffic, compared against a history-list model of issued instructions.
module tb_fwd_hazard_unit;

  localparam int AW = 5, NSRC = 2, DEPTH = 3, LD_READY = 2, SW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [NSRC*AW-1:0]  id_src;
  logic [NSRC-1:0]     id_src_use;
  logic [AW-1:0]       id_rw;
  logic                id_regwr, id_isload, flush;
  logic                id_stall, ex_valid;
  logic [NSRC*SW-1:0]  ex_fwd_sel;
  logic [15:0]         stall_cnt;

  fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LD_READY(LD_READY)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_use(id_src_use), .id_rw(id_rw), .id_regwr(id_regwr),
    .id_isload(id_isload), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rw;
    bit       wr;
    bit       ld;
  } instr_t;

  // hist[a] = what entered EX a cycles before the current cycle (a=0 newest)
  instr_t hist[$];
  int     m_cnt;
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    instr_t b;
    b = '{v: 0, rw: 0, wr: 0, ld: 0};
    hist.delete();
    for (int a = 0; a < DEPTH; a++) hist.push_back(b);
    m_cnt = 0;
  endtask

  // One ID cycle: drive at negedge, check stall, clock, check EX outputs.
  task automatic step(input bit v, input int s0, input int s1, input bit [1:0] use_,
                      input int rw, input bit wr, input bit ld, input bit fl);
    int     src[2];
    int     sel[2];
    bit     haz;
    bit     exp_stall, adv;
    instr_t e;
    @(negedge clk);
    id_valid = v; id_src = {5'(s1), 5'(s0)}; id_src_use = use_;
    id_rw = 5'(rw); id_regwr = wr; id_isload = ld; flush = fl;
    #1;
    src[0] = s0; src[1] = s1;
    haz = 0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0;
      if (use_[i] && src[i] != 0) begin
        // youngest in-flight writer of this register, ignoring the WB slot
        for (int a = 0; a < DEPTH - 1; a++) begin
          if (hist[a].v && hist[a].wr && hist[a].rw == src[i]) begin
            sel[i] = a + 1;
            if (hist[a].ld && (a + 1) < LD_READY) haz = 1;
            break;
          end
        end
      end
    end
    exp_stall = v && !fl && haz;
    adv       = v && !exp_stall && !fl;
    check("id_stall", {31'b0, id_stall}, {31'b0, exp_stall});
    @(posedge clk);
    #1;
    e = '{v: adv, rw: 5'(rw), wr: wr, ld: ld};
    hist.push_front(e);
    void'(hist.pop_back());
    if (exp_stall && m_cnt < 16'hFFFF) m_cnt++;
    check("ex_valid", {31'b0, ex_valid}, {31'b0, adv});
    check("ex_fwd_sel", {28'b0, ex_fwd_sel},
          adv ? {28'b0, 2'(sel[1]), 2'(sel[0])} : 32'd0);
    check("stall_cnt", {16'b0, stall_cnt}, 32'(m_cnt));
    last_stall = exp_stall;
  endtask

  initial begin
    id_valid = 0; id_src = '0; id_src_use = '0; id_rw = '0;
    id_regwr = 0; id_isload = 0; flush = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_stall", {31'b0, id_stall}, 32'd0);
    check("rst_exv", {31'b0, ex_valid}, 32'd0);
    check("rst_sel", {28'b0, ex_fwd_sel}, 32'd0);
    check("rst_cnt", {16'b0, stall_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;

    // ALU r1, then add r2 <- r1,r3 next cycle
    step(1, 0, 0, 2'b00, 1, 1, 0, 0);
    step(1, 1, 3, 2'b11, 2, 1, 0, 0);
    check("alu_b2b_sel", {28'b0, ex_fwd_sel}, 32'h1);
    // ALU r1, nop, use r1 -> 2 ; r1 three back -> 0
    step(1, 0, 0, 2'b00, 1, 1, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 1, 0, 2'b01, 6, 1, 0, 0);
    check("alu_gap_sel", {28'b0, ex_fwd_sel}, 32'h2);
    step(1, 0, 0, 2'b00, 7, 1, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 7, 0, 2'b01, 8, 1, 0, 0);
    check("far_sel", {28'b0, ex_fwd_sel}, 32'h0);
    // lw r2, use r2 as op1: one stall then select 2
    step(1, 0, 0, 2'b00, 2, 1, 1, 0);
    step(1, 5, 2, 2'b11, 9, 1, 0, 0);
    check("lu_stall_once", {31'b0, last_stall}, 32'd1);
    step(1, 5, 2, 2'b11, 9, 1, 0, 0);
    check("lu_resume", {31'b0, last_stall}, 32'd0);
    check("lu_sel", {28'b0, ex_fwd_sel}, 32'h8);
    check("lu_cnt", {16'b0, stall_cnt}, 32'd1);
    // lw r3, ALU r3, use r3 -> select 1, no stall
    step(1, 0, 0, 2'b00, 3, 1, 1, 0);
    step(1, 0, 0, 2'b00, 3, 1, 0, 0);
    step(1, 3, 0, 2'b01, 10, 1, 0, 0);
    check("young_alu_sel", {28'b0, ex_fwd_sel}, 32'h1);
    // r0 producer, regwr=0 producer, unused operand
    step(1, 0, 0, 2'b00, 0, 1, 1, 0);
    step(1, 0, 0, 2'b11, 11, 0, 1, 0);
    step(1, 11, 0, 2'b11, 12, 1, 1, 0);
    step(1, 12, 12, 2'b00, 13, 1, 0, 0);
    check("unused_sel", {28'b0, ex_fwd_sel}, 32'h0);
    // consumer writing its own source: r1 <- r1+1 twice
    step(1, 1, 0, 2'b01, 1, 1, 0, 0);
    step(1, 1, 0, 2'b01, 1, 1, 0, 0);
    // lw r4, use r4 with flush in stall cycle
    step(1, 0, 0, 2'b00, 4, 1, 1, 0);
    step(1, 4, 0, 2'b01, 14, 1, 0, 1);
    // lw r4, use r4, reset pulsed mid-stall
    step(1, 0, 0, 2'b00, 4, 1, 1, 0);
    @(negedge clk);
    id_valid = 1; id_src = {5'd0, 5'd4}; id_src_use = 2'b01;
    id_rw = 5'd15; id_regwr = 1; id_isload = 0; flush = 0;
    #1;
    check("pre_rst_stall", {31'b0, id_stall}, 32'd1);
    rst_n = 0;
    #1;
    check("mid_rst_stall", {31'b0, id_stall}, 32'd0);
    check("mid_rst_exv", {31'b0, ex_valid}, 32'd0);
    check("mid_rst_sel", {28'b0, ex_fwd_sel}, 32'd0);
    check("mid_rst_cnt", {16'b0, stall_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1;
    model_reset();
    step(1, 4, 0, 2'b01, 15, 1, 0, 0);
    check("post_rst_sel", {28'b0, ex_fwd_sel}, 32'h0);

    // Random traffic; a stalled ID instruction is re-presented unchanged.
    begin
      bit v, wr, ld, fl;
      int s0, s1, rw;
      bit [1:0] u;
      v = 0; wr = 0; ld = 0; fl = 0; s0 = 0; s1 = 0; rw = 0; u = 0;
      last_stall = 0;
      for (int n = 0; n < 2000; n++) begin
        if (!last_stall) begin
          v  = ($urandom_range(0, 9) != 0);
          s0 = $urandom_range(0, 4);
          s1 = $urandom_range(0, 4);
          u  = 2'($urandom_range(0, 3));
          rw = $urandom_range(0, 4);
          wr = ($urandom_range(0, 4) != 0);
          ld = ($urandom_range(0, 2) == 0);
        end
        fl = ($urandom_range(0, 14) == 0);
        step(v, s0, s1, u, rw, wr, ld, fl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU core. It tracks every in-flight register write from EX through WB in an internal record pipeline. When an instruction advances from ID to EX, the unit computes a registered per-operand bypass select for that instruction. It also stalls ID for as many cycles as a load result needs to become forwardable.

## Interface
Parameters:
- AW, 5: register address width.
- NSRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages, with index 0 = EX, 1 = MEM, …, DEPTH-1 = WB; DEPTH ≥ 2.
- LD_READY, 2: first stage index at which load data is forwardable; 1 ≤ LD_READY ≤ DEPTH-1.
- SW, derived: SW = $clog2(DEPTH); select field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_src  in  NSRC*AW  source register numbers; operand i occupies bits [i*AW +: AW].
- id_src_use  in  NSRC  operand i is actually read.
- id_rw  in  AW  destination register of the ID instruction.
- id_regwr  in  1  ID instruction writes id_rw.
- id_isload  in  1  ID instruction is a load.
- flush  in  1  kill the instructions in ID and EX (branch/jump redirect).
- id_stall  out  1  combinational; hold PC and IF/ID, inject a bubble into EX.
- ex_valid  out  1  registered; EX holds a valid instruction.
- ex_fwd_sel  out  NSRC*SW  registered; per operand: 0 = register file, k = stage k result (1 ≤ k ≤ DEPTH-1).
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Record pipeline rec[0..DEPTH-1]. Each record holds {v, rw, wr, ld}.
  - Every cycle, rec[j+1] ← rec[j].
  - rec[0] ← ID instruction when id_valid && !id_stall && !flush; otherwise rec[0] ← bubble (v=0).
- A record is a producer when v && wr && rw≠0. Register 0 is never forwarded or stalled on.
- Forward search, per used operand i with id_src_i≠0:
  - Scan rec[0..DEPTH-2] for a producer with rw == id_src_i.
  - The lowest index j (youngest producer) wins.
  - The candidate select is j+1, which is the stage that producer occupies when the consumer reaches EX.
  - No match gives select 0. Producers in rec[DEPTH-1] are not considered: the register file writes in the first half-cycle and covers them.
- Hazard: a winning producer with ld=1 and j+1 < LD_READY is a hazard. id_stall = id_valid && !flush && (any used operand hazard). Only the winning (youngest) producer is tested; an older load behind a younger ALU producer never stalls.
- Stall: ID is held, a bubble enters rec[0], and older records keep advancing. The hazard is recomputed every cycle, so a stall lasts LD_READY-1-j cycles.
- Registered outputs, updated on each clk edge:
  - ex_valid ← id_valid && !id_stall && !flush.
  - ex_fwd_sel ← computed selects when the instruction advances; all zeros otherwise.
  - Unused operands (id_src_use=0) always receive select 0.
- flush has priority over stall. When flush=1: id_stall=0, rec[0] and EX become bubbles, ex_fwd_sel=0. The records already in MEM and later stages keep advancing untouched.
- stall_cnt increments on every cycle with id_stall=1 and saturates at 16'hFFFF.

## Timing
- Reset (rst_n=0, asynchronous): all rec.v=0, ex_valid=0, ex_fwd_sel=0, stall_cnt=0, id_stall=0. Reset applied during a stall cancels it on the same cycle, with no residual records.
- Latency:
  - ex_fwd_sel and ex_valid are valid one cycle after the ID→EX advance, aligned with the instruction in EX.
  - id_stall is valid in the same cycle as its inputs.
- Back-to-back producers of the same register: the youngest wins, with no stall unless that youngest is a load that is not yet ready.
- A consumer that also writes the same register (e.g. r1←r1+1) forwards from older producers only; its own record is not visible to itself.
- id_valid=0: no stall, and a bubble enters EX.

## Test plan
Defaults: DEPTH=3, LD_READY=2, NSRC=2.
- ALU r1←…, then add r2←r1,r3 on the next cycle → ex_fwd_sel op0=1, op1=0, no stall.
- ALU r1←…, nop, then use r1 → op0 select=2; with r1 three instructions back → select 0.
- lw r2, then use r2 as op1 on the next cycle → id_stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then op1 select=2, stall_cnt=1. Repeat with one intervening nop → no stall, select 2.
- ALU r3 (older) and ALU r3 (younger) in flight, then use r3 → select 1. lw r3 then ALU r3, then use r3 → select 1, no stall.
- Producer with rw=0 or regwr=0, and consumer with id_src_use=0 → select 0 and no stall in all three cases.
- lw r4 then use r4 with flush asserted in the stall cycle → id_stall=0, ex_valid=0 next cycle. Repeat with rst_n pulsed low mid-stall → all outputs 0 immediately and stall_cnt=0.
